// File: rtl/cpu_pkg.sv
// Shared datapath definitions: flag bit positions, branch condition masks
// and the branch FSM state type.
package cpu_pkg;

  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

  localparam logic [2:0] COND_EQ = 3'b010;
  localparam logic [2:0] COND_NE = 3'b101;
  localparam logic [2:0] COND_LT = 3'b001;
  localparam logic [2:0] COND_GE = 3'b110;
  localparam logic [2:0] COND_GT = 3'b100;
  localparam logic [2:0] COND_LE = 3'b011;
  localparam logic [2:0] COND_AL = 3'b111;
  localparam logic [2:0] COND_NV = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    LOAD = 2'd2
  } br_state_t;

  // Exactly one bit set: odd parity with the all-ones case excluded.
  function automatic logic is_one_hot(input logic [2:0] v);
    return (v[FLAG_GT] ^ v[FLAG_EQ] ^ v[FLAG_LT]) &
           ~(v[FLAG_GT] & v[FLAG_EQ] & v[FLAG_LT]);
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Compare-flag register: latches one-hot comparator results and raises a
// sticky error when a malformed result is written.
module flag_reg
  import cpu_pkg::*;
#(
  parameter logic [2:0] FLAG_RST = 3'b010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmp,
  input  logic       cmp_we,
  output logic [2:0] flags,
  output logic       flag_err
);

  // A bad write leaves the flags untouched so later branches still see the
  // last legal compare result.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= FLAG_RST;
      flag_err <= 1'b0;
    end else if (cmp_we) begin
      if (is_one_hot(cmp)) begin
        flags <= cmp;
      end else begin
        flag_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_branch_unit.sv
// Branch resolution unit: evaluates a condition mask against the latched
// compare flags and performs the PC-load handshake with the fetch stage.
module cmp_branch_unit
  import cpu_pkg::*;
#(
  parameter int         PC_W     = 8,
  parameter logic [2:0] FLAG_RST = 3'b010
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      cmp,
  input  logic            cmp_we,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            pc_ready,
  output logic [2:0]      flags,
  output logic            flag_err,
  output logic            br_busy,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic            br_done,
  output logic            br_taken
);

  br_state_t  state;
  logic [2:0] cond_q;

  flag_reg #(
    .FLAG_RST(FLAG_RST)
  ) u_flag_reg (
    .clk     (clk),
    .rst     (rst),
    .cmp     (cmp),
    .cmp_we  (cmp_we),
    .flags   (flags),
    .flag_err(flag_err)
  );

  assign br_busy = (state != IDLE);

  // EVAL reads the registered flags, so a compare retiring alongside the
  // branch request is seen, while one retiring during EVAL is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cond_q    <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
    end else begin
      br_done  <= 1'b0;
      br_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (br_valid) begin
            cond_q    <= br_cond;
            pc_target <= br_target;
            state     <= EVAL;
          end
        end
        EVAL: begin
          if (|(flags & cond_q)) begin
            pc_load <= 1'b1;
            state   <= LOAD;
          end else begin
            br_done <= 1'b1;
            state   <= IDLE;
          end
        end
        LOAD: begin
          if (pc_ready) begin
            pc_load  <= 1'b0;
            br_done  <= 1'b1;
            br_taken <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_branch_unit.sv
// Self-checking bench for cmp_branch_unit: directed scenarios followed by
// randomized branches checked against a transaction-level model.
module tb_cmp_branch_unit;
  import cpu_pkg::*;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      cmp;
  logic            cmp_we;
  logic            br_valid;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic            pc_ready;
  logic [2:0]      flags;
  logic            flag_err;
  logic            br_busy;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic            br_done;
  logic            br_taken;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: flags and error as the rules define them.
  logic [2:0] m_flags;
  logic       m_err;

  cmp_branch_unit #(.PC_W(PC_W), .FLAG_RST(3'b010)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmp      (cmp),
    .cmp_we   (cmp_we),
    .br_valid (br_valid),
    .br_cond  (br_cond),
    .br_target(br_target),
    .pc_ready (pc_ready),
    .flags    (flags),
    .flag_err (flag_err),
    .br_busy  (br_busy),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .br_done  (br_done),
    .br_taken (br_taken)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [2:0] v);
    if ($countones(v) == 1) m_flags = v;
    else m_err = 1'b1;
  endtask

  task automatic write_flags(input logic [2:0] v);
    cmp    = v;
    cmp_we = 1'b1;
    step();
    cmp_we = 1'b0;
    model_write(v);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmp = 3'b000; cmp_we = 1'b0; br_valid = 1'b0;
    br_cond = 3'b000; br_target = '0; pc_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    m_flags = 3'b010; m_err = 1'b0;
    n_cmp++;
    if (flags !== 3'b010) begin n_err++; $display("[TB] FAIL reset_flags got %b exp 010", flags); end
    n_cmp++;
    if ({flag_err, br_busy, pc_load, br_done, br_taken} !== 5'b0 || pc_target !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL reset_outputs got err=%b busy=%b load=%b done=%b taken=%b tgt=%h exp all 0",
               flag_err, br_busy, pc_load, br_done, br_taken, pc_target);
    end
    write_flags(3'b001);
    n_cmp++;
    if (flags !== 3'b001) begin n_err++; $display("[TB] FAIL first_write got %b exp 001", flags); end
  endtask

  task automatic test_not_taken();
    bit saw_load = 0;
    write_flags(3'b100);
    br_valid = 1'b1; br_cond = COND_EQ; br_target = 8'h3C;
    step();
    br_valid = 1'b0;
    saw_load |= pc_load;
    n_cmp++;
    if (br_busy !== 1'b1 || br_done !== 1'b0) begin
      n_err++; $display("[TB] FAIL nt_eval got busy=%b done=%b exp 1 0", br_busy, br_done);
    end
    step();
    saw_load |= pc_load;
    n_cmp++;
    if (br_done !== 1'b1 || br_taken !== 1'b0 || br_busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL nt_done got done=%b taken=%b busy=%b exp 1 0 0", br_done, br_taken, br_busy);
    end
    step();
    saw_load |= pc_load;
    n_cmp++;
    if (br_done !== 1'b0 || saw_load) begin
      n_err++; $display("[TB] FAIL nt_after got done=%b saw_load=%0d exp 0 0", br_done, saw_load);
    end
  endtask

  task automatic test_taken_stall();
    write_flags(3'b001);
    br_valid = 1'b1; br_cond = COND_LE; br_target = 8'hA5;
    step();
    br_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      pc_ready = (i == 3);
      n_cmp++;
      if (pc_load !== 1'b1 || pc_target !== 8'hA5 || br_done !== 1'b0) begin
        n_err++; $display("[TB] FAIL stall_load[%0d] got load=%b tgt=%h done=%b exp 1 a5 0", i, pc_load, pc_target, br_done);
      end
      step();
    end
    pc_ready = 1'b0;
    n_cmp++;
    if (br_done !== 1'b1 || br_taken !== 1'b1 || pc_load !== 1'b0) begin
      n_err++; $display("[TB] FAIL stall_done got done=%b taken=%b load=%b exp 1 1 0", br_done, br_taken, pc_load);
    end
    step();
    n_cmp++;
    if (br_done !== 1'b0 || br_taken !== 1'b0) begin
      n_err++; $display("[TB] FAIL stall_pulse got done=%b taken=%b exp 0 0", br_done, br_taken);
    end
  endtask

  task automatic test_forwarding();
    write_flags(3'b010);
    br_valid = 1'b1; br_cond = COND_GT; br_target = 8'h42;
    cmp = 3'b100; cmp_we = 1'b1;
    step();
    model_write(3'b100);
    br_valid = 1'b0; cmp_we = 1'b0;
    step();
    n_cmp++;
    if (pc_load !== 1'b1) begin n_err++; $display("[TB] FAIL fwd_same got load=%b exp 1", pc_load); end
    pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    n_cmp++;
    if (br_done !== 1'b1 || br_taken !== 1'b1) begin
      n_err++; $display("[TB] FAIL fwd_same_done got done=%b taken=%b exp 1 1", br_done, br_taken);
    end
    write_flags(3'b100);
    br_valid = 1'b1; br_cond = COND_GT; br_target = 8'h43;
    step();
    br_valid = 1'b0;
    cmp = 3'b010; cmp_we = 1'b1;
    step();
    cmp_we = 1'b0;
    model_write(3'b010);
    n_cmp++;
    if (pc_load !== 1'b1 || flags !== 3'b010) begin
      n_err++; $display("[TB] FAIL fwd_eval got load=%b flags=%b exp 1 010", pc_load, flags);
    end
    pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    n_cmp++;
    if (br_done !== 1'b1 || br_taken !== 1'b1) begin
      n_err++; $display("[TB] FAIL fwd_eval_done got done=%b taken=%b exp 1 1", br_done, br_taken);
    end
  endtask

  task automatic test_error_busy();
    write_flags(3'b011);
    n_cmp++;
    if (flags !== 3'b010 || flag_err !== 1'b1) begin
      n_err++; $display("[TB] FAIL err_write got flags=%b err=%b exp 010 1", flags, flag_err);
    end
    write_flags(3'b001);
    step();
    n_cmp++;
    if (flag_err !== 1'b1 || flags !== 3'b001) begin
      n_err++; $display("[TB] FAIL err_sticky got err=%b flags=%b exp 1 001", flag_err, flags);
    end
    br_valid = 1'b1; br_cond = COND_AL; br_target = 8'h5A;
    step();
    br_valid = 1'b0;
    step();
    br_valid = 1'b1; br_target = 8'h11;
    step(); step();
    n_cmp++;
    if (pc_load !== 1'b1 || pc_target !== 8'h5A) begin
      n_err++; $display("[TB] FAIL busy_ignore got load=%b tgt=%h exp 1 5a", pc_load, pc_target);
    end
    br_valid = 1'b0; pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    step();
    n_cmp++;
    if (br_busy !== 1'b0 || pc_target !== 8'h5A) begin
      n_err++; $display("[TB] FAIL busy_after got busy=%b tgt=%h exp 0 5a", br_busy, pc_target);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    write_flags(3'b100);
    br_valid = 1'b1; br_cond = COND_GT; br_target = 8'h77;
    step();
    br_valid = 1'b0;
    step();
    n_cmp++;
    if (pc_load !== 1'b1) begin n_err++; $display("[TB] FAIL mid_load got %b exp 1", pc_load); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_flags = 3'b010; m_err = 1'b0;
    saw_done |= br_done;
    n_cmp++;
    if (pc_load !== 1'b0 || flags !== 3'b010 || br_busy !== 1'b0 || flag_err !== 1'b0) begin
      n_err++; $display("[TB] FAIL mid_reset got load=%b flags=%b busy=%b err=%b exp 0 010 0 0",
                        pc_load, flags, br_busy, flag_err);
    end
    pc_ready = 1'b1;
    step(); step();
    pc_ready = 1'b0;
    saw_done |= br_done;
    n_cmp++;
    if (saw_done || br_busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL mid_nodone got saw_done=%0d busy=%b exp 0 0", saw_done, br_busy);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      logic [2:0]      c;
      logic [PC_W-1:0] tgt;
      logic            exp_taken;
      int              stall, lat, exp_lat;
      bit              tgt_bad;
      if ($urandom_range(0, 3) != 0) write_flags(3'($urandom_range(0, 7)));
      c   = 3'($urandom_range(0, 7));
      tgt = PC_W'($urandom);
      br_valid = 1'b1; br_cond = c; br_target = tgt;
      cmp = 3'($urandom_range(0, 7)); cmp_we = $urandom_range(0, 1) != 0;
      pc_ready = $urandom_range(0, 1) != 0;
      step();
      if (cmp_we) model_write(cmp);
      exp_taken = |(m_flags & c);
      stall     = $urandom_range(0, 3);
      exp_lat   = exp_taken ? stall + 2 : 1;
      br_valid  = 1'b0;
      cmp = 3'($urandom_range(0, 7)); cmp_we = $urandom_range(0, 1) != 0;
      pc_ready = $urandom_range(0, 1) != 0;
      if (cmp_we) model_write(cmp);
      lat = 0; tgt_bad = 0;
      while (lat < 20) begin
        step();
        cmp_we = 1'b0;
        lat++;
        if (br_done) break;
        if (pc_load) begin
          if (pc_target !== tgt) tgt_bad = 1;
          pc_ready = (stall == 0);
          if (stall > 0) stall--;
        end
      end
      pc_ready = 1'b0;
      n_cmp++;
      if (br_done !== 1'b1 || br_taken !== exp_taken || lat != exp_lat || tgt_bad) begin
        n_err++; $display("[TB] FAIL rand_br[%0d] got done=%b taken=%b lat=%0d tgt_bad=%0d exp 1 %b %0d 0",
                          t, br_done, br_taken, lat, tgt_bad, exp_taken, exp_lat);
      end
      n_cmp++;
      if (flags !== m_flags || flag_err !== m_err) begin
        n_err++; $display("[TB] FAIL rand_flags[%0d] got %b/%b exp %b/%b", t, flags, flag_err, m_flags, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_not_taken();
    test_taken_stall();
    test_forwarding();
    test_error_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
